// File: rtl/pixel_smooth.sv
// Avalon-ST 3-tap horizontal smoothing filter ([1 2 1]/4 per channel) with edge
// replication, non-video packet bypass, and an MM slave for control/status.
module pixel_smooth #(
    parameter logic [10:0] IMAGE_W   = 11'd640,
    parameter logic [31:0] SMOOTH_ID = 32'h1234EEE3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] sink_data,
    input  logic        sink_valid,
    input  logic        sink_sop,
    input  logic        sink_eop,
    output logic        sink_ready,
    output logic [23:0] source_data,
    output logic        source_valid,
    output logic        source_sop,
    output logic        source_eop,
    input  logic        source_ready,
    input  logic        s_chipselect,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [1:0]  s_address,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata
);

    typedef enum logic [1:0] {EMPTY, HOLD, FLUSH} state_e;

    state_e      state_q, state_d;
    logic [10:0] x_q, x_d;
    logic        active_q, active_d;
    logic        video_q, video_d;
    logic        smooth_q, smooth_d;
    logic        eop_q, eop_d;
    logic [23:0] l_q, l_d, c_q, c_d;
    logic        src_valid_q, src_valid_d;
    logic        src_sop_q, src_sop_d;
    logic        src_eop_q, src_eop_d;
    logic [23:0] src_data_q, src_data_d;
    logic        ctrl_en_q, ctrl_en_d;
    logic [15:0] fc_q, fc_d;
    logic [31:0] rdata_q, rdata_d;

    logic        out_free, flush_trunc, accept, pix_last;
    logic        emit, em_sop, em_eop, em_video;
    logic [23:0] em_data;
    logic        wdata_unused;

    function automatic logic [7:0] f8(input logic [7:0] l, input logic [7:0] c, input logic [7:0] r);
        logic [9:0] acc;
        acc = {2'b00, l} + {1'b0, c, 1'b0} + {2'b00, r} + 10'd2;
        return acc[9:2];
    endfunction

    function automatic logic [23:0] f24(input logic [23:0] l, input logic [23:0] c, input logic [23:0] r);
        return {f8(l[23:16], c[23:16], r[23:16]),
                f8(l[15:8],  c[15:8],  r[15:8]),
                f8(l[7:0],   c[7:0],   r[7:0])};
    endfunction

    assign wdata_unused = ^s_writedata[31:1];
    assign out_free     = !src_valid_q || source_ready;
    // A sop arriving mid-line forces the held pixel out as a line end before the sop is taken.
    assign flush_trunc  = (state_q == HOLD) && sink_valid && sink_sop;
    assign sink_ready   = !reset && (state_q != FLUSH) && !flush_trunc && out_free;
    assign accept       = sink_valid && sink_ready;
    assign pix_last     = (x_q == IMAGE_W - 11'd1) || sink_eop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept && !sink_sop && active_q && smooth_q && !pix_last) state_d = HOLD;
            HOLD: begin
                if (flush_trunc) begin
                    if (out_free) state_d = EMPTY;
                end else if (accept && pix_last) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: if (out_free) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        x_d      = x_q;
        active_d = active_q;
        video_d  = video_q;
        smooth_d = smooth_q;
        eop_d    = eop_q;
        l_d      = l_q;
        c_d      = c_q;
        emit     = 1'b0;
        em_data  = '0;
        em_sop   = 1'b0;
        em_eop   = 1'b0;
        em_video = video_q;

        if (state_q == FLUSH) begin
            if (out_free) begin
                emit    = 1'b1;
                em_data = f24(l_q, c_q, c_q);
                em_eop  = eop_q;
            end
        end else if (flush_trunc) begin
            if (out_free) begin
                emit    = 1'b1;
                em_data = f24(l_q, c_q, c_q);
            end
        end else if (accept) begin
            if (sink_sop) begin
                emit     = 1'b1;
                em_data  = sink_data;
                em_sop   = 1'b1;
                em_eop   = sink_eop;
                em_video = (sink_data[3:0] == 4'd0);
                x_d      = '0;
                video_d  = em_video;
                smooth_d = ctrl_en_q && em_video;
                active_d = !sink_eop;
            end else if (active_q) begin
                x_d      = (x_q == IMAGE_W - 11'd1) ? 11'd0 : x_q + 11'd1;
                active_d = !sink_eop;
                if (!smooth_q || (state_q == EMPTY && pix_last)) begin
                    emit    = 1'b1;
                    em_data = sink_data;
                    em_eop  = sink_eop;
                end else if (state_q == EMPTY) begin
                    l_d = sink_data;
                    c_d = sink_data;
                end else begin
                    emit    = 1'b1;
                    em_data = f24(l_q, c_q, sink_data);
                    l_d     = c_q;
                    c_d     = sink_data;
                    eop_d   = sink_eop;
                end
            end
        end

        src_valid_d = out_free ? 1'b0 : src_valid_q;
        src_data_d  = src_data_q;
        src_sop_d   = src_sop_q;
        src_eop_d   = src_eop_q;
        if (emit) begin
            src_valid_d = 1'b1;
            src_data_d  = em_data;
            src_sop_d   = em_sop;
            src_eop_d   = em_eop;
        end

        ctrl_en_d = ctrl_en_q;
        fc_d      = fc_q;
        if (s_chipselect && s_write && s_address == 2'd0) ctrl_en_d = s_writedata[0];
        if (s_chipselect && s_write && s_address == 2'd1) fc_d = '0;
        else if (emit && em_eop && em_video)              fc_d = fc_q + 16'd1;

        rdata_d = rdata_q;
        if (s_chipselect && s_read) begin
            case (s_address)
                2'd0:    rdata_d = {31'd0, ctrl_en_q};
                2'd1:    rdata_d = {16'd0, fc_q};
                2'd2:    rdata_d = SMOOTH_ID;
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q         <= '0;
            active_q    <= 1'b0;
            video_q     <= 1'b0;
            smooth_q    <= 1'b0;
            eop_q       <= 1'b0;
            l_q         <= '0;
            c_q         <= '0;
            src_valid_q <= 1'b0;
            src_sop_q   <= 1'b0;
            src_eop_q   <= 1'b0;
            src_data_q  <= '0;
            ctrl_en_q   <= 1'b1;
            fc_q        <= '0;
            rdata_q     <= '0;
        end else begin
            x_q         <= x_d;
            active_q    <= active_d;
            video_q     <= video_d;
            smooth_q    <= smooth_d;
            eop_q       <= eop_d;
            l_q         <= l_d;
            c_q         <= c_d;
            src_valid_q <= src_valid_d;
            src_sop_q   <= src_sop_d;
            src_eop_q   <= src_eop_d;
            src_data_q  <= src_data_d;
            ctrl_en_q   <= ctrl_en_d;
            fc_q        <= fc_d;
            rdata_q     <= rdata_d;
        end
    end

    assign source_valid = src_valid_q;
    assign source_sop   = src_sop_q;
    assign source_eop   = src_eop_q;
    assign source_data  = src_data_q;
    assign s_readdata   = rdata_q;

endmodule

// File: tb/tb_pixel_smooth.sv
// Directed bench for pixel_smooth with a 4-pixel line; expected beats are hand-computed.
module tb_pixel_smooth;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] sink_data;
    logic        sink_valid, sink_sop, sink_eop;
    logic        sink_ready;
    logic [23:0] source_data;
    logic        source_valid, source_sop, source_eop;
    logic        source_ready;
    logic        s_chipselect, s_read, s_write;
    logic [1:0]  s_address;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [25:0] outq[$];
    logic        rand_en = 1'b0;
    logic        ready_cmd = 1'b1;
    logic        stall_q = 1'b0;
    logic [25:0] prev_beat = '0;
    logic [31:0] rd;

    pixel_smooth #(.IMAGE_W(11'd4)) dut (
        .clk(clk), .reset(reset),
        .sink_data(sink_data), .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
        .sink_ready(sink_ready),
        .source_data(source_data), .source_valid(source_valid), .source_sop(source_sop),
        .source_eop(source_eop), .source_ready(source_ready),
        .s_chipselect(s_chipselect), .s_read(s_read), .s_write(s_write),
        .s_address(s_address), .s_writedata(s_writedata), .s_readdata(s_readdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // source_ready changes 2 time units after each rising edge.
    initial begin
        source_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            source_ready = rand_en ? 1'($urandom_range(0, 1)) : ready_cmd;
        end
    end

    // Record transferred beats and check stability of stalled output.
    always @(negedge clk) begin
        if (reset) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q)
                chk("stall_hold", 32'({source_valid, source_sop, source_eop, source_data}),
                    32'({1'b1, prev_beat}));
            if (source_valid && source_ready)
                outq.push_back({source_sop, source_eop, source_data});
            stall_q   = source_valid && !source_ready;
            prev_beat = {source_sop, source_eop, source_data};
        end
    end

    task automatic send(input logic [23:0] d, input logic s, input logic e);
        int   n;
        logic ok;
        n = 0;
        ok = 1'b0;
        sink_data = d; sink_sop = s; sink_eop = e; sink_valid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = sink_ready;
            @(posedge clk);
            #1;
            n++;
        end
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
        chk("sink_accept", 32'(ok), 32'd1);
    endtask

    task automatic expect_out(input string tag, input logic [23:0] d, input logic s, input logic e);
        int n;
        n = 0;
        while (outq.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("out_available", 32'(outq.size() != 0), 32'd1);
        if (outq.size() != 0) chk(tag, 32'(outq.pop_front()), 32'({s, e, d}));
    endtask

    task automatic mm_write(input logic [1:0] a, input logic [31:0] d);
        s_chipselect = 1'b1; s_write = 1'b1; s_address = a; s_writedata = d;
        @(posedge clk);
        #1;
        s_chipselect = 1'b0; s_write = 1'b0;
    endtask

    task automatic mm_read(input logic [1:0] a, output logic [31:0] d);
        s_chipselect = 1'b1; s_read = 1'b1; s_address = a;
        @(posedge clk);
        #1;
        s_chipselect = 1'b0; s_read = 1'b0;
        d = s_readdata;
    endtask

    task automatic send_ramp_line(input logic [7:0] step);
        send(24'h000000, 1'b0, 1'b0);
        send({step, 16'h0}, 1'b0, 1'b0);
        send({step + step, 16'h0}, 1'b0, 1'b0);
        send({step + step + step, 16'h0}, 1'b0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        sink_data = '0; sink_valid = 1'b1; sink_sop = 1'b0; sink_eop = 1'b0;
        s_chipselect = 1'b0; s_read = 1'b0; s_write = 1'b0; s_address = '0; s_writedata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(source_valid), 32'd0);
        chk("rst_sop_eop", 32'({source_sop, source_eop}), 32'd0);
        chk("rst_data", 32'(source_data), 32'd0);
        chk("rst_sink_ready", 32'(sink_ready), 32'd0);
        chk("rst_readdata", s_readdata, 32'd0);
        sink_valid = 1'b0;
        reset = 1'b0;

        mm_read(2'd0, rd); chk("ctrl_reset", rd, 32'd1);
        mm_read(2'd1, rd); chk("fc_reset", rd, 32'd0);
        mm_read(2'd2, rd); chk("id", rd, 32'h1234EEE3);
        mm_read(2'd3, rd); chk("addr3", rd, 32'd0);
        mm_write(2'd0, 32'hFFFFFFFF);
        mm_read(2'd0, rd); chk("ctrl_mask", rd, 32'd1);

        // Smoothing of a ramp line: 0,4,8,12 -> 1,4,8,11.
        send(24'h000000, 1'b1, 1'b0);
        send(24'h000000, 1'b0, 1'b0);
        send(24'h040000, 1'b0, 1'b0);
        send(24'h080000, 1'b0, 1'b0);
        send(24'h0C0000, 1'b0, 1'b1);
        expect_out("ramp_sop", 24'h000000, 1'b1, 1'b0);
        expect_out("ramp_p0", 24'h010000, 1'b0, 1'b0);
        expect_out("ramp_p1", 24'h040000, 1'b0, 1'b0);
        expect_out("ramp_p2", 24'h080000, 1'b0, 1'b0);
        expect_out("ramp_p3", 24'h0B0000, 1'b0, 1'b1);
        mm_read(2'd1, rd); chk("fc_after_ramp", rd, 32'd1);

        // Control packet passes through bit-exact with one cycle latency.
        send(24'hABCDE5, 1'b1, 1'b0);
        chk("ctl_latency", 32'({source_valid, source_sop, source_data}), 32'({2'b11, 24'hABCDE5}));
        send(24'h123456, 1'b0, 1'b0);
        send(24'h789ABC, 1'b0, 1'b1);
        expect_out("ctl_w0", 24'hABCDE5, 1'b1, 1'b0);
        expect_out("ctl_w1", 24'h123456, 1'b0, 1'b0);
        expect_out("ctl_w2", 24'h789ABC, 1'b0, 1'b1);
        mm_read(2'd1, rd); chk("fc_after_ctl", rd, 32'd1);

        // Saturated channels, line cut short by eop on the third pixel.
        send(24'h000000, 1'b1, 1'b0);
        send(24'hFFFFFF, 1'b0, 1'b0);
        send(24'hFFFFFF, 1'b0, 1'b0);
        send(24'hFFFFFF, 1'b0, 1'b1);
        expect_out("sat_sop", 24'h000000, 1'b1, 1'b0);
        expect_out("sat_p0", 24'hFFFFFF, 1'b0, 1'b0);
        expect_out("sat_p1", 24'hFFFFFF, 1'b0, 1'b0);
        expect_out("sat_p2", 24'hFFFFFF, 1'b0, 1'b1);
        mm_read(2'd1, rd); chk("fc_after_sat", rd, 32'd2);

        // Two 2-line frames under random backpressure.
        rand_en = 1'b1;
        for (int f = 0; f < 2; f++) begin
            send(24'h000000, 1'b1, 1'b0);
            send_ramp_line(8'd4);
            send(24'h000064, 1'b0, 1'b0);
            send(24'h000000, 1'b0, 1'b0);
            send(24'h000064, 1'b0, 1'b0);
            send(24'h000000, 1'b0, 1'b1);
        end
        for (int f = 0; f < 2; f++) begin
            expect_out("rnd_sop", 24'h000000, 1'b1, 1'b0);
            expect_out("rnd_a0", 24'h010000, 1'b0, 1'b0);
            expect_out("rnd_a1", 24'h040000, 1'b0, 1'b0);
            expect_out("rnd_a2", 24'h080000, 1'b0, 1'b0);
            expect_out("rnd_a3", 24'h0B0000, 1'b0, 1'b0);
            expect_out("rnd_b0", 24'h00004B, 1'b0, 1'b0);
            expect_out("rnd_b1", 24'h000032, 1'b0, 1'b0);
            expect_out("rnd_b2", 24'h000032, 1'b0, 1'b0);
            expect_out("rnd_b3", 24'h000019, 1'b0, 1'b1);
        end
        rand_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mm_read(2'd1, rd); chk("fc_after_rnd", rd, 32'd4);

        // Single-pixel line is passed through unmodified.
        send(24'h000000, 1'b1, 1'b0);
        send(24'h102030, 1'b0, 1'b1);
        expect_out("one_sop", 24'h000000, 1'b1, 1'b0);
        expect_out("one_px", 24'h102030, 1'b0, 1'b1);
        mm_read(2'd1, rd); chk("fc_after_one", rd, 32'd5);

        // Disable mid-frame: current frame stays smoothed, next frame bypassed.
        send(24'h000000, 1'b1, 1'b0);
        send(24'h000000, 1'b0, 1'b0);
        mm_write(2'd0, 32'd0);
        send(24'h040000, 1'b0, 1'b0);
        send(24'h080000, 1'b0, 1'b0);
        send(24'h0C0000, 1'b0, 1'b1);
        expect_out("dis_sop", 24'h000000, 1'b1, 1'b0);
        expect_out("dis_p0", 24'h010000, 1'b0, 1'b0);
        expect_out("dis_p1", 24'h040000, 1'b0, 1'b0);
        expect_out("dis_p2", 24'h080000, 1'b0, 1'b0);
        expect_out("dis_p3", 24'h0B0000, 1'b0, 1'b1);
        mm_read(2'd0, rd); chk("ctrl_cleared", rd, 32'd0);
        send(24'h000000, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++)
            send({8'(i), 8'(2 * i), 8'(255 - i)}, 1'b0, 1'(i == 11));
        expect_out("byp_sop", 24'h000000, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++)
            expect_out("byp_px", {8'(i), 8'(2 * i), 8'(255 - i)}, 1'b0, 1'(i == 11));
        mm_read(2'd1, rd); chk("fc_after_byp", rd, 32'd7);
        mm_write(2'd0, 32'd1);

        // Truncated frame: held pixel drains as a line end before the new sop.
        send(24'h000000, 1'b1, 1'b0);
        send(24'h000000, 1'b0, 1'b0);
        send(24'h040000, 1'b0, 1'b0);
        send(24'h000000, 1'b1, 1'b0);
        send(24'h102030, 1'b0, 1'b1);
        expect_out("tr_sop", 24'h000000, 1'b1, 1'b0);
        expect_out("tr_p0", 24'h010000, 1'b0, 1'b0);
        expect_out("tr_flush", 24'h030000, 1'b0, 1'b0);
        expect_out("tr_sop2", 24'h000000, 1'b1, 1'b0);
        expect_out("tr_px", 24'h102030, 1'b0, 1'b1);
        mm_read(2'd1, rd); chk("fc_after_tr", rd, 32'd8);

        // Clear of frame_count in the same cycle as an eop increment.
        send(24'h000000, 1'b1, 1'b0);
        sink_data = 24'h102030; sink_sop = 1'b0; sink_eop = 1'b1; sink_valid = 1'b1;
        s_chipselect = 1'b1; s_write = 1'b1; s_address = 2'd1; s_writedata = '0;
        @(negedge clk);
        chk("clr_accept", 32'(sink_ready), 32'd1);
        @(posedge clk);
        #1;
        sink_valid = 1'b0; sink_eop = 1'b0; s_chipselect = 1'b0; s_write = 1'b0;
        expect_out("clr_sop", 24'h000000, 1'b1, 1'b0);
        expect_out("clr_px", 24'h102030, 1'b0, 1'b1);
        mm_read(2'd1, rd); chk("fc_clear_wins", rd, 32'd0);

        // Reset while holding a pixel with a stalled output.
        send(24'h000000, 1'b1, 1'b0);
        send(24'h000000, 1'b0, 1'b0);
        send(24'h040000, 1'b0, 1'b0);
        ready_cmd = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(source_valid), 32'd0);
        chk("async_rst_ready", 32'(sink_ready), 32'd0);
        expect_out("hr_sop", 24'h000000, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ready_cmd = 1'b1;
        send(24'h0C0000, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_drop", 32'(outq.size()), 32'd0);
        mm_read(2'd0, rd); chk("post_rst_ctrl", rd, 32'd1);
        send(24'h000000, 1'b1, 1'b0);
        send(24'h102030, 1'b0, 1'b1);
        expect_out("pr_sop", 24'h000000, 1'b1, 1'b0);
        expect_out("pr_px", 24'h102030, 1'b0, 1'b1);
        mm_read(2'd1, rd); chk("fc_post_rst", rd, 32'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(outq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
